// File: rtl/datamover_s2mm_responder_if.sv
// Command, write-data and status AXI-Stream channels of the S2MM responder.
// master is the command/data source and status sink; slave is the responder.
interface datamover_s2mm_responder_if #(
    parameter int unsigned DDR_ADDR_WIDTH = 40
);
    logic [40+DDR_ADDR_WIDTH-1:0] i_cmd_tdata;
    logic                         i_cmd_tvalid;
    logic                         o_cmd_tready;

    logic [63:0]                  i_wr_tdata;
    logic [7:0]                   i_wr_tkeep;
    logic                         i_wr_tvalid;
    logic                         i_wr_tlast;
    logic                         o_wr_tready;

    logic [7:0]                   o_sts_tdata;
    logic                         o_sts_tkeep;
    logic                         o_sts_tlast;
    logic                         o_sts_tvalid;
    logic                         i_sts_tready;

    modport master (
        output i_cmd_tdata, i_cmd_tvalid, i_wr_tdata, i_wr_tkeep, i_wr_tvalid, i_wr_tlast,
               i_sts_tready,
        input  o_cmd_tready, o_wr_tready, o_sts_tdata, o_sts_tkeep, o_sts_tlast, o_sts_tvalid
    );

    modport slave (
        input  i_cmd_tdata, i_cmd_tvalid, i_wr_tdata, i_wr_tkeep, i_wr_tvalid, i_wr_tlast,
               i_sts_tready,
        output o_cmd_tready, o_wr_tready, o_sts_tdata, o_sts_tkeep, o_sts_tlast, o_sts_tvalid
    );
endinterface

// File: rtl/datamover_s2mm_responder.sv
// S2MM datamover responder: accepts one command, checks and sums its write beats, returns status.
// Optional macro S2MM_RESP_BACKPRESSURE_EN gates o_wr_tready with a 16-bit LFSR.
module datamover_s2mm_responder #(
    parameter int unsigned               DDR_ADDR_WIDTH = 40,
    parameter logic [DDR_ADDR_WIDTH:0]   ADDR_LIMIT     = (DDR_ADDR_WIDTH+1)'(40'h80_0000_0000)
) (
    input  logic                          clk,
    input  logic                          rst,
    datamover_s2mm_responder_if.slave     bus,
    output logic                          o_busy,
    output logic [63:0]                   o_data_sum,
    output logic [15:0]                   o_cmd_count
);
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_DRAIN, S_STS} state_e;

    state_e                    state_q, state_d;
    logic [22:0]               btt_q, btt_d;
    logic [3:0]                tag_q, tag_d;
    logic [DDR_ADDR_WIDTH-1:0] saddr_q, saddr_d;
    logic                      interr_q, interr_d;
    logic [19:0]               beat_q, beat_d;
    logic [63:0]               sum_q, sum_d;
    logic [15:0]               count_q, count_d;

    logic [22:0]               cmd_btt;
    logic [3:0]                cmd_tag;
    logic [DDR_ADDR_WIDTH-1:0] cmd_saddr;
    logic                      unused_cmd_bits;
    logic                      cmd_fire, wr_fire, sts_fire;
    logic [19:0]               exp_beats, beat_next;
    logic [7:0]                exp_keep;
    logic                      is_last;
    logic [DDR_ADDR_WIDTH:0]   end_addr;
    logic                      decerr;
    logic [63:0]               beat_masked;
    logic                      bp_ok;

    assign cmd_btt         = bus.i_cmd_tdata[22:0];
    assign cmd_saddr       = bus.i_cmd_tdata[32 +: DDR_ADDR_WIDTH];
    assign cmd_tag         = bus.i_cmd_tdata[32+DDR_ADDR_WIDTH +: 4];
    assign unused_cmd_bits = ^{bus.i_cmd_tdata[31:23], bus.i_cmd_tdata[36+DDR_ADDR_WIDTH +: 4]};

    assign cmd_fire = bus.i_cmd_tvalid & bus.o_cmd_tready;
    assign wr_fire  = bus.i_wr_tvalid  & bus.o_wr_tready;
    assign sts_fire = bus.o_sts_tvalid & bus.i_sts_tready;

    assign exp_beats = 20'(({1'b0, btt_q} + 24'd7) >> 3);
    assign exp_keep  = (btt_q[2:0] == 3'd0) ? 8'hFF : 8'((8'd1 << btt_q[2:0]) - 8'd1);
    assign beat_next = beat_q + 20'd1;
    assign is_last   = (beat_next == exp_beats);
    // Decode error is derived from the latched command, so it clears with it after status.
    assign end_addr  = {1'b0, saddr_q} + (DDR_ADDR_WIDTH+1)'(btt_q);
    assign decerr    = (end_addr > ADDR_LIMIT);

    always_comb begin
        for (int b = 0; b < 8; b++) begin
            beat_masked[8*b +: 8] = bus.i_wr_tkeep[b] ? bus.i_wr_tdata[8*b +: 8] : 8'h00;
        end
    end

`ifdef S2MM_RESP_BACKPRESSURE_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign bp_ok  = (lfsr_q[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= 16'hACE1;
        else     lfsr_q <= lfsr_d;
    end
`else
    assign bp_ok = 1'b1;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_fire) state_d = (cmd_btt == 23'd0) ? S_STS : S_DATA;
            S_DATA:  if (wr_fire) begin
                         if (is_last)              state_d = bus.i_wr_tlast ? S_STS : S_DRAIN;
                         else if (bus.i_wr_tlast)  state_d = S_STS;
                     end
            S_DRAIN: if (wr_fire && bus.i_wr_tlast) state_d = S_STS;
            S_STS:   if (sts_fire) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.o_cmd_tready = 1'b0;
        bus.o_wr_tready  = 1'b0;
        bus.o_sts_tvalid = 1'b0;
        bus.o_sts_tdata  = 8'h00;
        bus.o_sts_tkeep  = 1'b0;
        bus.o_sts_tlast  = 1'b0;
        o_busy           = 1'b0;
        if (!rst) begin
            o_busy = (state_q != S_IDLE);
            case (state_q)
                S_IDLE:          bus.o_cmd_tready = 1'b1;
                S_DATA, S_DRAIN: bus.o_wr_tready  = bp_ok;
                S_STS: begin
                    bus.o_sts_tvalid = 1'b1;
                    bus.o_sts_tdata  = {~(interr_q | decerr), 1'b0, decerr, interr_q, tag_q};
                    bus.o_sts_tkeep  = 1'b1;
                    bus.o_sts_tlast  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        btt_d    = btt_q;
        tag_d    = tag_q;
        saddr_d  = saddr_q;
        interr_d = interr_q;
        beat_d   = beat_q;
        sum_d    = sum_q;
        count_d  = count_q;
        case (state_q)
            S_IDLE: if (cmd_fire) begin
                btt_d    = cmd_btt;
                tag_d    = cmd_tag;
                saddr_d  = cmd_saddr;
                interr_d = (cmd_btt == 23'd0);
                beat_d   = 20'd0;
                sum_d    = 64'd0;
            end
            S_DATA: if (wr_fire) begin
                beat_d = beat_next;
                sum_d  = sum_q + beat_masked;
                if (is_last) begin
                    if (bus.i_wr_tkeep != exp_keep || !bus.i_wr_tlast) interr_d = 1'b1;
                end else if (bus.i_wr_tlast) begin
                    interr_d = 1'b1;
                end
            end
            S_STS: if (sts_fire) begin
                count_d  = count_q + 16'd1;
                interr_d = 1'b0;
                btt_d    = 23'd0;
                tag_d    = 4'd0;
                saddr_d  = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btt_q    <= 23'd0;
            tag_q    <= 4'd0;
            saddr_q  <= '0;
            interr_q <= 1'b0;
            beat_q   <= 20'd0;
            sum_q    <= 64'd0;
            count_q  <= 16'd0;
        end else begin
            btt_q    <= btt_d;
            tag_q    <= tag_d;
            saddr_q  <= saddr_d;
            interr_q <= interr_d;
            beat_q   <= beat_d;
            sum_q    <= sum_d;
            count_q  <= count_d;
        end
    end

    assign o_data_sum  = sum_q;
    assign o_cmd_count = count_q;
endmodule

// File: doc/datamover_s2mm_responder.md
DATAMOVER_S2MM_RESPONDER -- requirements
Module: datamover_s2mm_responder

Interface
REQ-001 The block SHALL have parameter DDR_ADDR_WIDTH, default 40, the command address width.
REQ-002 The block SHALL have parameter ADDR_LIMIT, default 40'h80_0000_0000, the exclusive upper bound of the decodable address window.
REQ-003 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- i_cmd_tdata  in  40+DDR_ADDR_WIDTH  command: [22:0] BTT, [23] type, [29:24] DSA, [30] EOF, [31] DRR, [71:32] SADDR, [75:72] TAG, [79:76] reserved.
- i_cmd_tvalid  in  1  command valid.
- o_cmd_tready  out  1  command ready.
- i_wr_tdata  in  64  write data.
- i_wr_tkeep  in  8  byte enables.
- i_wr_tvalid  in  1  data valid.
- i_wr_tlast  in  1  last beat.
- o_wr_tready  out  1  data ready.
- o_sts_tdata  out  8  status: [3:0] TAG, [4] INTERR, [5] DECERR, [6] SLVERR (always 0), [7] OKAY.
- o_sts_tkeep  out  1  constant 1 whenever o_sts_tvalid is high.
- o_sts_tlast  out  1  constant 1 whenever o_sts_tvalid is high.
- o_sts_tvalid  out  1  status valid.
- i_sts_tready  in  1  status ready.
- o_busy  out  1  high in every state except IDLE.
- o_data_sum  out  64  running 64-bit wrap-around sum of accepted beats with unkept bytes masked to zero; cleared on command accept.
- o_cmd_count  out  16  number of status words transferred, wraps at 16'hFFFF.

Function
REQ-004 The FSM SHALL have states IDLE, DATA, DRAIN, STS.
REQ-005 In IDLE, o_cmd_tready SHALL be 1; a transfer with i_cmd_tvalid high SHALL latch BTT, TAG and SADDR and move to DATA, or move directly to STS when BTT==0.
REQ-006 Expected beats SHALL be ceil(BTT/8), computed in 20 bits; expected last-beat keep SHALL be 8'hFF when BTT[2:0]==0, otherwise (1<<BTT[2:0])-1.
REQ-007 DECERR SHALL be set when SADDR+BTT, computed in DDR_ADDR_WIDTH+1 bits, exceeds ADDR_LIMIT; the data phase still executes.
REQ-008 In DATA, o_wr_tready SHALL be 1 (subject to REQ-020); every beat with tvalid and tready high SHALL increment the beat count and update o_data_sum in the same cycle.
REQ-009 A beat with tlast high before the expected last beat SHALL set INTERR and move to STS.
REQ-010 On the expected last beat, a tlast mismatch with tkeep SHALL set INTERR; with tlast high the FSM SHALL move to STS, otherwise INTERR SHALL be set and the FSM SHALL move to DRAIN.
REQ-011 In DRAIN, o_wr_tready SHALL be 1, beats SHALL be discarded (no sum update), and a beat with tlast high SHALL move the FSM to STS.
REQ-012 BTT==0 SHALL set INTERR and accept no data.
REQ-013 In STS, o_sts_tvalid SHALL be 1 and o_sts_tdata SHALL be held stable until i_sts_tready is high; OKAY SHALL be ~(INTERR|DECERR).
REQ-014 On the status handshake, o_cmd_count SHALL increment, the error flags SHALL clear, and the FSM SHALL return to IDLE; no new command SHALL be accepted in the same cycle.
REQ-015 o_cmd_tready and o_wr_tready SHALL be 0 in STS; o_cmd_tready SHALL be 0 in DATA and DRAIN.
REQ-016 Data presented in IDLE SHALL NOT be accepted (o_wr_tready=0).

Reset
REQ-017 On rst the FSM SHALL enter IDLE and all latched command fields and error flags SHALL clear.
REQ-018 On rst, o_sts_tvalid, o_sts_tdata, o_data_sum, o_cmd_count, o_busy and o_wr_tready SHALL be 0, and o_cmd_tready SHALL be 1 from the first cycle after reset release.
REQ-019 A reset asserted mid-transfer SHALL drop the pending transfer and its status without emitting a status word.

Configuration
REQ-020 With macro S2MM_RESP_BACKPRESSURE_EN defined, a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on rst) SHALL gate o_wr_tready in DATA and DRAIN, deasserting it whenever LFSR[1:0]==2'b00; without the macro there SHALL be no LFSR and tready SHALL be as in REQ-008/011.

Verification
REQ-021 Cmd BTT=64, TAG=4'hA, SADDR=0; 8 beats with tkeep=FF and tlast on beat 8 -> status 8'h8A, o_cmd_count=1.
REQ-022 Cmd BTT=20, TAG=3; 3 beats with last tkeep=8'h0F and tlast on beat 3 -> status 8'h83; o_data_sum equals the masked sum.
REQ-023 Cmd BTT=64, TAG=1; tlast on beat 5 -> status 8'h11 after beat 5, with no further beats accepted.
REQ-024 Cmd BTT=16, TAG=2; 4 beats with tlast on beat 4 -> beats 3-4 drained; status 8'h12.
REQ-025 Cmd SADDR=ADDR_LIMIT-8, BTT=16, TAG=5; 2 correct beats -> status 8'h25; cmd BTT=0, TAG=6 -> status 8'h16 with no data accepted.
REQ-026 Hold i_sts_tready=0 for 10 cycles in STS -> o_sts_tvalid and o_sts_tdata stable and o_cmd_tready=0; assert rst during DATA -> IDLE, no status emitted, o_cmd_count unchanged at 0.
